// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time and fills a
// two-entry instruction buffer, with redirect handling and flush of in-flight data.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   // state     | meaning
   // S_BOOT    | one idle cycle after reset release
   // S_FETCH   | request outstanding at fetch_pc
   // S_WAIT_ROOM | buffer full, no request
   // S_FLUSH   | redirect seen while request pending; drop its data on ack
   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT_ROOM, S_FLUSH} state_t;

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] e0_pc_q, e0_pc_d, e0_data_q, e0_data_d;
   logic [31:0] e1_pc_q, e1_pc_d, e1_data_q, e1_data_d;

   logic        ack, pop, push, flush;
   logic [1:0]  cnt_np;
   logic [31:0] redir_tgt;

   assign imem_req    = (state_q == S_FETCH) || (state_q == S_FLUSH);
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (cnt_q != 2'd0);
   assign instr       = e0_data_q;
   assign instr_pc    = e0_pc_q;

   always_comb begin
      ack        = imem_req && imem_ack;
      pop        = instr_valid && instr_ready;
      redir_tgt  = redirect_pc & 32'hFFFF_FFFC;
      cnt_np     = cnt_q - {1'b0, pop};
      push       = 1'b0;
      flush      = 1'b0;
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      redir_pc_d = redir_pc_q;
      cnt_d      = cnt_q;
      e0_pc_d    = e0_pc_q;
      e0_data_d  = e0_data_q;
      e1_pc_d    = e1_pc_q;
      e1_data_d  = e1_data_q;

      case (state_q)
         S_BOOT: begin
            state_d    = S_FETCH;
            fetch_pc_d = RESET_PC;
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redir_tgt;
            end
         end
         S_FETCH: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (ack) begin
                  fetch_pc_d = redir_tgt;
               end else begin
                  redir_pc_d = redir_tgt;
                  state_d    = S_FLUSH;
               end
            end else if (ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = ((cnt_np + 2'd1) >= FULL) ? S_WAIT_ROOM : S_FETCH;
            end
         end
         S_WAIT_ROOM: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redir_tgt;
               state_d    = S_FETCH;
            end else if (pop) begin
               state_d = S_FETCH;
            end
         end
         S_FLUSH: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               redir_pc_d = redir_tgt;
            end
            // a redirect arriving on the ack cycle wins over the latched one
            if (ack) begin
               fetch_pc_d = redirect_valid ? redir_tgt : redir_pc_q;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_BOOT;
      endcase

      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_data_d = e1_data_q;
         end
         if (push) begin
            if (cnt_np == 2'd0) begin
               e0_pc_d   = fetch_pc_q;
               e0_data_d = imem_rdata;
            end else begin
               e1_pc_d   = fetch_pc_q;
               e1_data_d = imem_rdata;
            end
         end
         cnt_d = cnt_np + {1'b0, push};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         redir_pc_q <= 32'd0;
         cnt_q      <= 2'd0;
         e0_pc_q    <= 32'd0;
         e0_data_q  <= 32'd0;
         e1_pc_q    <= 32'd0;
         e1_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         redir_pc_q <= redir_pc_d;
         cnt_q      <= cnt_d;
         e0_pc_q    <= e0_pc_d;
         e0_data_q  <= e0_data_d;
         e1_pc_q    <= e1_pc_d;
         e1_data_q  <= e1_data_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for the main flow plus hand
// sequences for reset-mid-transfer and address wrap.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   logic        w_req, w_vld;
   logic [31:0] w_addr, w_instr, w_pc;
   logic        w_ack = 1'b1;
   logic        w_rdy = 1'b1;
   logic        w_rv = 1'b0;
   logic [31:0] w_rpc = 32'd0;
   logic [31:0] w_rdata = 32'h1234_5678;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
      .clk(clk), .rst(rst),
      .redirect_valid(w_rv), .redirect_pc(w_rpc),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata),
      .instr_valid(w_vld), .instr(w_instr), .instr_pc(w_pc),
      .instr_ready(w_rdy)
   );

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rv, logic [31:0] rpc, logic ack, logic [31:0] rdata,
                               logic rdy, logic e_req, logic [31:0] e_addr, logic e_vld,
                               logic [31:0] e_instr, logic [31:0] e_pc);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      // rv rpc ack rdata rdy | req addr vld instr pc
      vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0,   0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0000, 1, 1, 32'h4,   1, 32'hD000_0000, 32'h0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0004, 1, 1, 32'h8,   1, 32'hD000_0004, 32'h4));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0008, 1, 1, 32'hC,   1, 32'hD000_0008, 32'h8));
      vecs.push_back(mk(0, 0, 1, 32'hD000_000C, 1, 1, 32'h10,  1, 32'hD000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h10,  0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0010, 0, 1, 32'h14,  1, 32'hD000_0010, 32'h10));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0014, 0, 0, 32'h18,  1, 32'hD000_0010, 32'h10));
      vecs.push_back(mk(0, 0, 1, 32'hDEAD_0000, 0, 0, 32'h18,  1, 32'hD000_0010, 32'h10));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h18,  1, 32'hD000_0014, 32'h14));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h18,  1, 32'hD000_0014, 32'h14));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 1, 32'h18,  0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h18,  0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0018, 0, 1, 32'h100, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0100, 0, 1, 32'h104, 1, 32'hD000_0100, 32'h100));
      vecs.push_back(mk(1, 32'h300, 0, 32'h0,   0, 1, 32'h104, 0, 0, 0));
      vecs.push_back(mk(1, 32'h403, 0, 32'h0,   0, 1, 32'h104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0104, 0, 1, 32'h400, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0400, 0, 1, 32'h404, 1, 32'hD000_0400, 32'h400));
      vecs.push_back(mk(1, 32'h200, 1, 32'hD000_0404, 1, 1, 32'h200, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0200, 1, 1, 32'h204, 1, 32'hD000_0200, 32'h200));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0204, 0, 0, 32'h208, 1, 32'hD000_0200, 32'h200));
      vecs.push_back(mk(1, 32'h50, 0, 32'h0,    0, 1, 32'h50,  0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0050, 0, 1, 32'h54,  1, 32'hD000_0050, 32'h50));
      vecs.push_back(mk(0, 0, 1, 32'hD000_0054, 0, 0, 32'h58,  1, 32'hD000_0050, 32'h50));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 0, 32'(imem_req), 32'd0);
      chk("rst_addr", 0, imem_addr, 32'h0);
      chk("rst_vld", 0, 32'(instr_valid), 32'd0);
      chk("rst_instr", 0, instr, 32'h0);
      chk("rst_pc", 0, instr_pc, 32'h0);
      chk("rst_wrap_addr", 0, w_addr, 32'hFFFF_FFF8);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("boot_req", 0, 32'(imem_req), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         imem_ack       = vecs[i].ack;
         imem_rdata     = vecs[i].rdata;
         instr_ready    = vecs[i].rdy;
         @(posedge clk);
         #1;
         chk("req", i, 32'(imem_req), 32'(vecs[i].e_req));
         chk("addr", i, imem_addr, vecs[i].e_addr);
         chk("vld", i, 32'(instr_valid), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk("instr", i, instr, vecs[i].e_instr);
            chk("instr_pc", i, instr_pc, vecs[i].e_pc);
         end
      end

      // reset pulsed while buffer is full and ack is still being driven
      redirect_valid = 1'b0;
      @(negedge clk);
      imem_ack    = 1'b1;
      instr_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_req", 0, 32'(imem_req), 32'd0);
      chk("mid_rst_addr", 0, imem_addr, 32'h0);
      chk("mid_rst_vld", 0, 32'(instr_valid), 32'd0);
      chk("mid_rst_instr", 0, instr, 32'h0);
      chk("mid_rst_pc", 0, instr_pc, 32'h0);
      chk("mid_rst_wrap_addr", 0, w_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_boot_req", 0, 32'(imem_req), 32'd0);
      chk("rel_boot_wreq", 0, 32'(w_req), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_fetch_req", 1, 32'(imem_req), 32'd1);
      chk("rel_fetch_addr", 1, imem_addr, 32'h0);
      chk("rel_late_ack_vld", 1, 32'(instr_valid), 32'd0);
      chk("wrap_addr", 1, w_addr, 32'hFFFF_FFF8);
      chk("wrap_req", 1, 32'(w_req), 32'd1);
      imem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_hold_addr", 2, imem_addr, 32'h0);
      chk("wrap_addr", 2, w_addr, 32'hFFFF_FFFC);
      chk("wrap_pc", 2, w_pc, 32'hFFFF_FFF8);
      chk("wrap_instr", 2, w_instr, 32'h1234_5678);
      @(posedge clk);
      #1;
      chk("wrap_addr", 3, w_addr, 32'h0000_0000);
      chk("wrap_pc", 3, w_pc, 32'hFFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, default 2, fetch buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-006 redirect_pc  input  32  redirect target, valid with redirect_valid.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  memory response; transfer completes when imem_req && imem_ack at a clock edge.
REQ-010 imem_rdata  input  32  read data, valid with imem_ack.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr  output  32  instruction at buffer head.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 instr_ready  input  1  consumer pops the head when instr_valid && instr_ready.

Function
REQ-015 FSM states: BOOT, FETCH, WAIT_ROOM, FLUSH; encoding is free.
REQ-016 BOOT lasts exactly one cycle after reset release, then goes to FETCH with fetch_pc = RESET_PC.
REQ-017 FETCH: imem_req = 1 and imem_addr = fetch_pc; address held stable until the ack edge.
REQ-018 On ack in FETCH: {fetch_pc, imem_rdata} is pushed into the buffer, and fetch_pc += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-019 After an ack, the FSM stays in FETCH when occupancy after push/pop < 2; otherwise it goes to WAIT_ROOM. Back-to-back requests carry no idle cycle.
REQ-020 At most one request is outstanding; occupancy never exceeds 2.
REQ-021 WAIT_ROOM: imem_req = 0; returns to FETCH the cycle after a pop.
REQ-022 instr_valid is asserted the cycle after the push edge; the ack-to-valid latency is 1 cycle.
REQ-023 Simultaneous push and pop when occupancy = 2: both are performed, and occupancy stays at 2.
REQ-024 Simultaneous push and pop when occupancy = 1: the head advances to the new entry, and occupancy stays at 1.
REQ-025 A redirect with no request pending or with ack in the same cycle: the buffer is flushed, any same-cycle ack data is discarded, fetch_pc = redirect_pc, and the next state is FETCH.
REQ-026 A redirect while a request is pending without ack: the next state is FLUSH.
REQ-027 FLUSH: imem_req stays 1 with the old address until ack. Returned data is discarded, then fetch_pc = redirect_pc and the next state is FETCH.
REQ-028 redirect_pc is latched on redirect_valid; a second redirect during FLUSH overwrites the latched target.
REQ-029 A redirect takes priority over a same-cycle pop and push. instr_valid = 0 the cycle after a redirect.
REQ-030 redirect_pc[1:0] is forced to 0 when latched.
REQ-031 instr and instr_pc hold their value while instr_valid && !instr_ready.

Reset
REQ-032 rst low asynchronously forces: state = BOOT, occupancy = 0, discard flag = 0, fetch_pc = RESET_PC.
REQ-033 Reset values of outputs: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-034 Reset asserted mid-transfer abandons the pending request; a late imem_ack after reset release is ignored unless imem_req = 1.

Verification
REQ-035 Reset release, ack every cycle, instr_ready = 1 -> imem_addr sequence 0, 4, 8, 12; instr_pc follows one cycle after each ack.
REQ-036 instr_ready = 0, ack every cycle -> two pushes (PC 0, 4), then imem_req = 0. Raise instr_ready -> imem_req = 1 at addr 8 the cycle after the pop.
REQ-037 Redirect to 32'h100 while the req to addr 8 waits 3 cycles for ack -> FLUSH, PC-8 data discarded, next imem_addr = 32'h100, and no PC-8 instruction is ever valid.
REQ-038 Redirect to 32'h200 in the same cycle as ack of addr 4 and a pop -> buffer empty next cycle, next imem_addr = 32'h200.
REQ-039 RESET_PC = 32'hFFFF_FFF8, free-running -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 rst pulsed low mid-request with occupancy 2 -> outputs immediately at reset values; after release, BOOT one cycle, then a fetch at RESET_PC.
